// File: rtl/alt_vipcti131_cvi_resolution_monitor_pkg.sv
// Shared definitions for the CVI resolution monitor: FSM encoding and
// register/interrupt/status bit positions used by the control slave.
package alt_vipcti131_cvi_resolution_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_SOF,
    ST_MEASURE
  } state_t;

  localparam int unsigned NUM_REGS    = 3;
  localparam int unsigned REG_STATUS  = 0;
  localparam int unsigned REG_SAMPLES = 1;
  localparam int unsigned REG_LINES   = 2;

  localparam int unsigned INT_UPDATE  = 0;
  localparam int unsigned INT_STABLE  = 1;

  localparam int unsigned STAT_STABLE = 0;
  localparam int unsigned STAT_OVF    = 1;

endpackage

// File: rtl/alt_vipcti131_cvi_sync_edge.sv
// Two-flop input register for a sync signal with rising-edge detect on the
// first stage.
module alt_vipcti131_cvi_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/alt_vipcti131_cvi_resolution_monitor.sv
// Measures active samples/line and lines/frame of the incoming video, publishes
// them to the control slave and tracks resolution stability.
module alt_vipcti131_cvi_resolution_monitor
  import alt_vipcti131_cvi_resolution_monitor_pkg::*;
#(
  parameter int unsigned AV_DATA_WIDTH = 16,
  parameter int unsigned COUNT_WIDTH   = 14,
  parameter int unsigned STABLE_FRAMES = 3
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  vid_datavalid,
  input  logic                                  vid_h_sync,
  input  logic                                  vid_v_sync,
  input  logic                                  enable,
  output logic                                  stopped,
  output logic [1:0]                            interrupts,
  output logic [NUM_REGS*AV_DATA_WIDTH-1:0]     registers_in,
  output logic [NUM_REGS-1:0]                   registers_write
);

  localparam int unsigned DW = AV_DATA_WIDTH;
  localparam int unsigned CW = COUNT_WIDTH;
  localparam logic [3:0] SF = 4'(STABLE_FRAMES);
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t state, next_state;

  logic          dv_s1;
  logic          h_rise, v_rise;
  logic [CW-1:0] samp_cnt, line_cnt, last_samp;
  logic          ovf;
  logic [CW-1:0] samp_next, lines_next, last_next;
  logic          ovf_next, line_close;
  logic          frame_start, frame_end;

  logic          pend_pub, stop_req;
  logic [CW-1:0] frame_samp, frame_lines;
  logic          frame_ovf;
  logic [CW-1:0] prev_samp, prev_lines;
  logic          prev_valid;
  logic [3:0]    match_cnt, match_next;
  logic          stable, stable_new, same;
  logic [DW-1:0] status_word;

  always_ff @(posedge clk) begin
    if (rst) dv_s1 <= 1'b0;
    else     dv_s1 <= vid_datavalid;
  end

  alt_vipcti131_cvi_sync_edge u_h_edge (.clk(clk), .rst(rst), .d(vid_h_sync), .rise(h_rise));
  alt_vipcti131_cvi_sync_edge u_v_edge (.clk(clk), .rst(rst), .d(vid_v_sync), .rise(v_rise));

  // A line closed on the frame-ending edge still belongs to the ending frame;
  // the coincident sample (if any) opens the next line.
  always_comb begin
    line_close = h_rise && (samp_cnt != '0);
    samp_next  = samp_cnt;
    if (line_close)                           samp_next = CW'(dv_s1);
    else if (dv_s1 && samp_cnt != CNT_MAX)    samp_next = samp_cnt + CW'(1);
    lines_next = (line_close && line_cnt != CNT_MAX) ? line_cnt + CW'(1) : line_cnt;
    last_next  = line_close ? samp_cnt : last_samp;
    ovf_next   = ovf | (line_close && line_cnt == CNT_MAX)
                     | (dv_s1 && !line_close && samp_cnt == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    case (state)
      ST_IDLE: if (enable) next_state = ST_WAIT_SOF;
      ST_WAIT_SOF: begin
        if (!enable) next_state = ST_IDLE;
        else if (v_rise) begin
          next_state  = ST_MEASURE;
          frame_start = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (pend_pub && stop_req) next_state = ST_IDLE;
        else if (v_rise)          frame_end = 1'b1;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt    <= '0;
      line_cnt    <= '0;
      last_samp   <= '0;
      ovf         <= 1'b0;
      pend_pub    <= 1'b0;
      stop_req    <= 1'b0;
      frame_samp  <= '0;
      frame_lines <= '0;
      frame_ovf   <= 1'b0;
    end else begin
      pend_pub <= frame_end;
      if (frame_end) begin
        frame_samp  <= last_next;
        frame_lines <= lines_next;
        frame_ovf   <= ovf_next;
        stop_req    <= !enable;
      end
      if (frame_start || frame_end) begin
        samp_cnt  <= CW'(dv_s1);
        line_cnt  <= '0;
        last_samp <= '0;
        ovf       <= 1'b0;
      end else if (state == ST_MEASURE) begin
        samp_cnt  <= samp_next;
        line_cnt  <= lines_next;
        last_samp <= last_next;
        ovf       <= ovf_next;
      end
    end
  end

  always_comb begin
    same       = prev_valid && (frame_samp == prev_samp) && (frame_lines == prev_lines);
    match_next = 4'd1;
    if (same) match_next = (match_cnt >= SF) ? match_cnt : match_cnt + 4'd1;
    stable_new = (match_next >= SF);
    status_word = '0;
    status_word[STAT_OVF]    = frame_ovf;
    status_word[STAT_STABLE] = stable_new;
  end

  // First IDLE cycle is recognised by stopped still being low.
  always_ff @(posedge clk) begin
    if (rst) begin
      stopped         <= 1'b1;
      interrupts      <= '0;
      registers_in    <= '0;
      registers_write <= '0;
      prev_samp       <= '0;
      prev_lines      <= '0;
      prev_valid      <= 1'b0;
      match_cnt       <= '0;
      stable          <= 1'b0;
    end else begin
      stopped         <= (state == ST_IDLE);
      interrupts      <= '0;
      registers_write <= '0;
      if (pend_pub) begin
        registers_write                            <= '1;
        registers_in[REG_STATUS*DW +: DW]          <= status_word;
        registers_in[REG_SAMPLES*DW +: DW]         <= DW'(frame_samp);
        registers_in[REG_LINES*DW +: DW]           <= DW'(frame_lines);
        interrupts[INT_UPDATE]                     <= !same;
        interrupts[INT_STABLE]                     <= (stable_new != stable);
        match_cnt                                  <= match_next;
        stable                                     <= stable_new;
        prev_samp                                  <= frame_samp;
        prev_lines                                 <= frame_lines;
        prev_valid                                 <= 1'b1;
      end else if (state == ST_IDLE && !stopped) begin
        registers_write[REG_STATUS]                <= 1'b1;
        registers_in[REG_STATUS*DW + STAT_STABLE]  <= 1'b0;
        interrupts[INT_STABLE]                     <= stable;
        stable                                     <= 1'b0;
        match_cnt                                  <= '0;
        prev_valid                                 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alt_vipcti131_cvi_resolution_monitor.sv
// Directed bench for the resolution monitor: scaled-down frames, stability,
// enable drop, coincident syncs, mid-frame reset and counter saturation.
module tb_alt_vipcti131_cvi_resolution_monitor;

  localparam int unsigned DW = 16;
  localparam int unsigned WA = 80;
  localparam int unsigned WB = 64;
  localparam int unsigned HA = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vid_datavalid = 1'b0;
  logic vid_h_sync = 1'b0;
  logic vid_v_sync = 1'b0;
  logic enable = 1'b1;

  logic          stopped, b_stopped;
  logic [1:0]    interrupts, b_interrupts;
  logic [3*DW-1:0] registers_in, b_registers_in;
  logic [2:0]    registers_write, b_registers_write;

  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alt_vipcti131_cvi_resolution_monitor #(.AV_DATA_WIDTH(16), .COUNT_WIDTH(14), .STABLE_FRAMES(3)) dut (
    .clk(clk), .rst(rst), .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync),
    .vid_v_sync(vid_v_sync), .enable(enable), .stopped(stopped), .interrupts(interrupts),
    .registers_in(registers_in), .registers_write(registers_write));

  alt_vipcti131_cvi_resolution_monitor #(.AV_DATA_WIDTH(16), .COUNT_WIDTH(8), .STABLE_FRAMES(3)) dut_b (
    .clk(clk), .rst(rst), .vid_datavalid(vid_datavalid), .vid_h_sync(vid_h_sync),
    .vid_v_sync(vid_v_sync), .enable(enable), .stopped(b_stopped), .interrupts(b_interrupts),
    .registers_in(b_registers_in), .registers_write(b_registers_write));

  // Write-event recorder for the main instance
  int cyc = 0, pub_n = 0, pub_cyc = 0, idle_n = 0, idle_cyc = 0, bad_wr = 0, stray = 0;
  logic [DW-1:0] last_r0, last_r1, last_r2, idle_r0;
  logic [1:0] last_int, idle_int;

  always @(negedge clk) begin
    cyc++;
    if (registers_write == 3'b111) begin
      pub_n++; pub_cyc = cyc;
      last_r0 = registers_in[0 +: DW];
      last_r1 = registers_in[DW +: DW];
      last_r2 = registers_in[2*DW +: DW];
      last_int = interrupts;
    end else if (registers_write == 3'b001) begin
      idle_n++; idle_cyc = cyc;
      idle_r0 = registers_in[0 +: DW];
      idle_int = interrupts;
    end else if (registers_write != 3'b000) begin
      bad_wr++;
    end
    if (registers_write == 3'b000 && interrupts != 2'b00) stray++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic dv, input logic h, input logic v);
    @(negedge clk);
    vid_datavalid = dv;
    vid_h_sync = h;
    vid_v_sync = v;
  endtask

  task automatic send_lines(input int unsigned n, input int unsigned w, input bit skip_last_h);
    for (int unsigned l = 0; l < n; l++) begin
      for (int unsigned s = 0; s < w; s++) tick(1'b1, 1'b0, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0);
      if (!(skip_last_h && l == n - 1)) repeat (2) tick(1'b0, 1'b1, 1'b0);
      repeat (2) tick(1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic send_vpulse(input bit with_h);
    repeat (2) tick(1'b0, with_h, 1'b1);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
  endtask

  int pub_before;

  initial begin
    // Reset state
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("rst_stopped", 64'(stopped), 64'd1);
    chk("rst_int", 64'(interrupts), 64'd0);
    chk("rst_regs", 64'(registers_in), 64'd0);
    chk("rst_wr", 64'(registers_write), 64'd0);
    rst = 1'b0;
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    chk("run_stopped", 64'(stopped), 64'd0);

    // 1: nominal frames, publish latency and stability build-up
    send_vpulse(1'b0);
    send_lines(HA, WA, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    chk("lat_e0_wr", 64'(registers_write), 64'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("lat_e1_wr", 64'(registers_write), 64'd0);
    tick(1'b0, 1'b0, 1'b0);
    chk("f1_wr", 64'(registers_write), 64'b111);
    chk("f1_samples", 64'(registers_in[DW +: DW]), 64'(WA));
    chk("f1_lines", 64'(registers_in[2*DW +: DW]), 64'(HA));
    chk("f1_status", 64'(registers_in[0 +: DW]), 64'd0);
    chk("f1_int", 64'(interrupts), 64'b01);
    tick(1'b0, 1'b0, 1'b0);
    chk("f1_wr_single", 64'(registers_write), 64'd0);
    chk("f1_int_single", 64'(interrupts), 64'd0);
    send_lines(HA, WA, 1'b0);
    send_vpulse(1'b0);
    chk("f2_pub_n", 64'(pub_n), 64'd2);
    chk("f2_int", 64'(last_int), 64'b00);
    chk("f2_status", 64'(last_r0), 64'd0);
    send_lines(HA, WA, 1'b0);
    send_vpulse(1'b0);
    chk("f3_int", 64'(last_int), 64'b10);
    chk("f3_status", 64'(last_r0), 64'd1);

    // 2: resolution change then recovery
    send_lines(HA, WB, 1'b0);
    send_vpulse(1'b0);
    chk("chg_int", 64'(last_int), 64'b11);
    chk("chg_status", 64'(last_r0), 64'd0);
    chk("chg_samples", 64'(last_r1), 64'(WB));
    send_lines(HA, WB, 1'b0);
    send_vpulse(1'b0);
    chk("chg2_int", 64'(last_int), 64'b00);
    send_lines(HA, WB, 1'b0);
    send_vpulse(1'b0);
    chk("chg3_int", 64'(last_int), 64'b10);
    chk("chg3_status", 64'(last_r0), 64'd1);

    // 3: enable dropped mid-frame
    pub_before = pub_n;
    send_lines(6, WB, 1'b0);
    enable = 1'b0;
    send_lines(6, WB, 1'b0);
    send_vpulse(1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    chk("dis_pub_n", 64'(pub_n), 64'(pub_before + 1));
    chk("dis_lines", 64'(last_r2), 64'(HA));
    chk("dis_int", 64'(last_int), 64'b00);
    chk("dis_idle_n", 64'(idle_n), 64'd1);
    chk("dis_idle_next", 64'(idle_cyc), 64'(pub_cyc + 1));
    chk("dis_idle_r0", 64'(idle_r0), 64'd0);
    chk("dis_idle_int", 64'(idle_int), 64'b10);
    chk("dis_stopped", 64'(stopped), 64'd1);

    // 5: coincident h/v sync closes the last line into the ending frame
    enable = 1'b1;
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    send_vpulse(1'b0);
    send_lines(HA, WA, 1'b1);
    send_vpulse(1'b1);
    chk("coin_lines", 64'(last_r2), 64'(HA));
    chk("coin_samples", 64'(last_r1), 64'(WA));
    chk("coin_int", 64'(last_int), 64'b01);

    // 6: reset mid-frame
    send_lines(5, WA, 1'b0);
    pub_before = pub_n;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_stopped", 64'(stopped), 64'd1);
    chk("mrst_int", 64'(interrupts), 64'd0);
    chk("mrst_regs", 64'(registers_in), 64'd0);
    chk("mrst_wr", 64'(registers_write), 64'd0);
    rst = 1'b0;
    repeat (4) tick(1'b0, 1'b0, 1'b0);
    send_vpulse(1'b0);
    chk("mrst_no_pub", 64'(pub_n), 64'(pub_before));
    send_lines(HA, WA, 1'b0);
    send_vpulse(1'b0);
    chk("mrst_pub_n", 64'(pub_n), 64'(pub_before + 1));
    chk("mrst_samples", 64'(last_r1), 64'(WA));
    chk("mrst_lines", 64'(last_r2), 64'(HA));
    chk("mrst_int2", 64'(last_int), 64'b01);

    // 4: 300-sample lines saturate the 8-bit instance only
    send_lines(4, 300, 1'b0);
    send_vpulse(1'b0);
    chk("sat_b_samples", 64'(b_registers_in[DW +: DW]), 64'd255);
    chk("sat_b_lines", 64'(b_registers_in[2*DW +: DW]), 64'd4);
    chk("sat_b_status", 64'(b_registers_in[0 +: DW]), 64'd2);
    chk("sat_a_samples", 64'(last_r1), 64'd300);
    chk("sat_a_status", 64'(last_r0), 64'd0);

    chk("bad_write_codes", 64'(bad_wr), 64'd0);
    chk("stray_interrupts", 64'(stray), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
